alu_host_driver: RTL and testbench
==================================

Name: alu_host_driver

Overview:
- Host-side initiator for the 16-bit serial ALU interface (in / nextstate / out).
- Accepts two 32-bit operands and a 4-bit func in parallel on a start strobe.
- Clears the ALU, streams A_lo, A_hi, B_lo, B_hi and func as nextstate-strobed 16-bit beats, then collects the two 16-bit result halves into one 32-bit word.
- Sits between the datapath control and the existing alu block, replacing hand-written stimulus sequencing.

Parameters:
- PULSE_CYC, 1, cycles alu_next is held high per beat (≥1).
- GAP_CYC, 2, low cycles after each pulse before the next data change or capture (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- op_a  input  32  operand A, latched on accepted start.
- op_b  input  32  operand B, latched on accepted start.
- func  input  4  ALU function code, latched on accepted start.
- busy  output  1  high from the accepted start through the done cycle.
- done  output  1  one-cycle pulse when result is valid.
- result  output  32  {hi,lo} ALU result; holds until the next done.
- alu_in  output  16  data beat to the ALU.
- alu_func  output  4  function code to the ALU.
- alu_next  output  1  nextstate strobe to the ALU.
- alu_clr  output  1  active-high clear to the ALU.
- alu_out  input  16  ALU result half.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, busy=0, done=0, result=0, alu_in=0, alu_func=0, alu_next=0, alu_clr=1. alu_clr holds the ALU in clear while reset is low.
- IDLE: alu_clr=0, alu_next=0. start=1 latches op_a, op_b and func and moves to CLR. start while busy is ignored; latched values do not change.
- CLR: 1 cycle. alu_clr=1, alu_in=op_a[15:0].
- Beat phase: PULSE_CYC cycles with alu_next=1, then GAP_CYC cycles with alu_next=0. alu_in and alu_func are stable for the whole phase. A single down-counter times every phase.
- Phase order:
  - LD_AL: op_a[15:0]
  - LD_AH: op_a[31:16]
  - LD_BL: op_b[15:0]
  - LD_BH: op_b[31:16]
  - EX1 and EX2: alu_func=func, alu_in=0
  - CAP_LO: on the last gap cycle of EX2, result[15:0]<=alu_out; then CAP_LO runs one beat phase.
  - CAP_HI: on the last gap cycle of CAP_LO, result[31:16]<=alu_out.
- DONE: 1 cycle, done=1, busy=1; then IDLE.
- Latency: done is high exactly 2+7*(PULSE_CYC+GAP_CYC) cycles after the edge that accepts start. This is 23 at the defaults.
- alu_func holds its last value after DONE. result is not updated at any point other than the two capture edges.
- Reset mid-operation: immediate return to IDLE. The partial result is discarded and result is cleared to 0. No done pulse is generated.
- start coincident with the DONE cycle: ignored. A new request needs start in IDLE, which gives back-to-back spacing of ≥1 idle cycle.
- Every op runs the full sequence, including unary ops (NOT) whose B beats are don't-care.

Decomposition:
- Package alu_drv_pkg:
  - func codes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5, SLA=6, SRA=7, SRL=8
  - state enum: IDLE, CLR, LD_AL, LD_AH, LD_BL, LD_BH, EX1, EX2, CAP_LO, DONE
  - PHASE_CYC = PULSE_CYC+GAP_CYC
- Sub-module beat_timer:
  - inputs: load, clk/reset
  - outputs: pulse (alu_next), last (final gap cycle)
  - driven by the FSM for every phase

Test Plan:
- ADD: op_a=0x0007_0002, op_b=0x0003_0003, func=0. Bench ALU model checks beat order A_lo, A_hi, B_lo, B_hi. Required: result=0x000A_0005, done at cycle 23.
- SUB: op_a=0x0003_0003, op_b=0x000B_0001, func=1. Required: result=0xFFF8_0002.
- SRA: op_a=0xB885_264A, op_b=1, func=7. Required: result=0xDC42_9325, with the sign bit propagated across the 16-bit halves.
- start pulsed at cycles 5 and 12 with different operands during an XOR (op_a=0x0805_020A, op_b=0x000F_0212). Required: result=0x080A_0018, exactly one done, busy continuous.
- reset low at cycle 9 of an OR op. Required: all outputs at reset values within the same cycle, no done, and the next ADD still correct.
- PULSE_CYC=2, GAP_CYC=3 build, NOT of 0x0825_220A. Required: result=0xF7DA_DDF5, done at cycle 37, alu_next high exactly 2 cycles per beat.

Source files
------------

// File: rtl/alu_drv_pkg.sv
// Shared types and timing helpers for the serial ALU host driver.
package alu_drv_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOT = 4'd5,
        ALU_SLA = 4'd6,
        ALU_SRA = 4'd7,
        ALU_SRL = 4'd8
    } alu_func_t;

    typedef enum logic [3:0] {
        IDLE, CLR, LD_AL, LD_AH, LD_BL, LD_BH, EX1, EX2, CAP_LO, DONE
    } state_t;

    localparam int PULSE_CYC_DEF = 1;
    localparam int GAP_CYC_DEF   = 2;

    function automatic int phase_cycles(input int pulse_cyc, input int gap_cyc);
        return pulse_cyc + gap_cyc;
    endfunction

    localparam int PHASE_CYC = phase_cycles(PULSE_CYC_DEF, GAP_CYC_DEF);

endpackage

// File: rtl/alu_host_driver_beat_timer.sv
// Down-counter that times one beat phase: PULSE_CYC strobe cycles, then GAP_CYC quiet cycles.
module beat_timer
    import alu_drv_pkg::*;
#(
    parameter int PULSE_CYC = PULSE_CYC_DEF,
    parameter int GAP_CYC   = GAP_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic pulse,
    output logic last
);

    localparam int PHASE = phase_cycles(PULSE_CYC, GAP_CYC);
    localparam int CW    = $clog2(PHASE + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(PHASE - 1);
    localparam logic [CW-1:0] CNT_GAP  = CW'(GAP_CYC);

    logic [CW-1:0] cnt_reg;
    logic          run_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
            run_reg <= 1'b0;
        end else if (load) begin
            cnt_reg <= CNT_LOAD;
            run_reg <= 1'b1;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CW'(1);
        end else begin
            run_reg <= 1'b0;
        end
    end

    // Count runs PHASE-1 down to 0; the top PULSE_CYC values are the strobe.
    assign pulse = run_reg && (cnt_reg >= CNT_GAP);
    assign last  = run_reg && (cnt_reg == '0);

endmodule

// File: rtl/alu_host_driver.sv
// Sequences clear, four operand beats, two execute beats and a capture beat to the serial ALU.
module alu_host_driver
    import alu_drv_pkg::*;
#(
    parameter int PULSE_CYC = PULSE_CYC_DEF,
    parameter int GAP_CYC   = GAP_CYC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [3:0]  func,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [15:0] alu_in,
    output logic [3:0]  alu_func,
    output logic        alu_next,
    output logic        alu_clr,
    input  logic [15:0] alu_out
);

    state_t      state_reg, state_next;
    logic [31:0] a_reg, b_reg, result_reg;
    logic [3:0]  func_reg, alu_func_reg;
    logic        load, pulse, last;

    beat_timer #(
        .PULSE_CYC (PULSE_CYC),
        .GAP_CYC   (GAP_CYC)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .pulse (pulse),
        .last  (last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            a_reg        <= '0;
            b_reg        <= '0;
            func_reg     <= '0;
            alu_func_reg <= '0;
            result_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && start) begin
                a_reg    <= op_a;
                b_reg    <= op_b;
                func_reg <= func;
            end
            if (state_reg == LD_BH && last)
                alu_func_reg <= func_reg;
            if (state_reg == EX2 && last)
                result_reg[15:0] <= alu_out;
            if (state_reg == CAP_LO && last)
                result_reg[31:16] <= alu_out;
        end
    end

    // Timer is reloaded on the cycle before each beat phase begins.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        case (state_reg)
            IDLE:   if (start) state_next = CLR;
            CLR:    begin state_next = LD_AL; load = 1'b1; end
            LD_AL:  if (last) begin state_next = LD_AH;  load = 1'b1; end
            LD_AH:  if (last) begin state_next = LD_BL;  load = 1'b1; end
            LD_BL:  if (last) begin state_next = LD_BH;  load = 1'b1; end
            LD_BH:  if (last) begin state_next = EX1;    load = 1'b1; end
            EX1:    if (last) begin state_next = EX2;    load = 1'b1; end
            EX2:    if (last) begin state_next = CAP_LO; load = 1'b1; end
            CAP_LO: if (last) state_next = DONE;
            DONE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        alu_in = '0;
        case (state_reg)
            CLR, LD_AL: alu_in = a_reg[15:0];
            LD_AH:      alu_in = a_reg[31:16];
            LD_BL:      alu_in = b_reg[15:0];
            LD_BH:      alu_in = b_reg[31:16];
            default:    alu_in = '0;
        endcase
    end

    assign alu_next = pulse;
    assign alu_clr  = !reset || (state_reg == CLR);
    assign alu_func = alu_func_reg;
    assign busy     = (state_reg != IDLE);
    assign done     = (state_reg == DONE);
    assign result   = result_reg;

endmodule

// File: tb/tb_alu_host_driver.sv
// Scoreboard bench: behavioural serial ALU per driver instance, expected results queued at start.
module tb_alu_host_driver;
    import alu_drv_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        start_w [2];
    logic [31:0] op_a_w [2], op_b_w [2], result_w [2];
    logic [3:0]  func_w [2], alu_func_w [2];
    logic        busy_w [2], done_w [2], alu_next_w [2], alu_clr_w [2];
    logic [15:0] alu_in_w [2], alu_out_w [2];

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q0 [$];
    logic [31:0] exp_q1 [$];
    logic [31:0] exp0_v, exp1_v;

    alu_host_driver dut (
        .clk(clk), .reset(reset), .start(start_w[0]), .op_a(op_a_w[0]), .op_b(op_b_w[0]),
        .func(func_w[0]), .busy(busy_w[0]), .done(done_w[0]), .result(result_w[0]),
        .alu_in(alu_in_w[0]), .alu_func(alu_func_w[0]), .alu_next(alu_next_w[0]),
        .alu_clr(alu_clr_w[0]), .alu_out(alu_out_w[0])
    );

    alu_host_driver #(.PULSE_CYC(2), .GAP_CYC(3)) dut_slow (
        .clk(clk), .reset(reset), .start(start_w[1]), .op_a(op_a_w[1]), .op_b(op_b_w[1]),
        .func(func_w[1]), .busy(busy_w[1]), .done(done_w[1]), .result(result_w[1]),
        .alu_in(alu_in_w[1]), .alu_func(alu_func_w[1]), .alu_next(alu_next_w[1]),
        .alu_clr(alu_clr_w[1]), .alu_out(alu_out_w[1])
    );

    // ---------------- behavioural serial ALU ----------------
    int          pulses [2] = '{0, 0};
    int          hi_len [2] = '{0, 0};
    int          wmin [2] = '{1000, 1000};
    int          wmax [2] = '{0, 0};
    int          done_seen [2] = '{0, 0};
    logic        prev_next [2] = '{1'b0, 1'b0};
    logic [15:0] rec [2][4];
    logic [15:0] ex_in [2] = '{16'h0, 16'h0};
    logic [3:0]  mfunc [2] = '{4'h0, 4'h0};
    logic [31:0] mres [2] = '{32'h0, 32'h0};

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] f);
        case (f)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return ~a;
            4'd6: return a << b[4:0];
            4'd7: return 32'($signed(a) >>> b[4:0]);
            4'd8: return a >> b[4:0];
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            prev_next[k] <= alu_next_w[k];
            if (alu_clr_w[k]) begin
                pulses[k] <= 0;
                hi_len[k] <= 0;
                wmin[k]   <= 1000;
                wmax[k]   <= 0;
                ex_in[k]  <= 16'h0;
            end else begin
                if (alu_next_w[k]) begin
                    hi_len[k] <= hi_len[k] + 1;
                end else if (prev_next[k]) begin
                    hi_len[k] <= 0;
                    if (hi_len[k] < wmin[k]) wmin[k] <= hi_len[k];
                    if (hi_len[k] > wmax[k]) wmax[k] <= hi_len[k];
                end
                if (alu_next_w[k] && !prev_next[k]) begin
                    pulses[k] <= pulses[k] + 1;
                    if (pulses[k] < 4) rec[k][pulses[k]] <= alu_in_w[k];
                    else if (pulses[k] < 6) ex_in[k] <= ex_in[k] | alu_in_w[k];
                    if (pulses[k] == 4) begin
                        mfunc[k] <= alu_func_w[k];
                        mres[k]  <= alu_ref({rec[k][1], rec[k][0]}, {rec[k][3], rec[k][2]},
                                            alu_func_w[k]);
                    end
                end
            end
        end
    end

    assign alu_out_w[0] = (pulses[0] == 6) ? mres[0][15:0] : (pulses[0] >= 7) ? mres[0][31:16] : 16'h0;
    assign alu_out_w[1] = (pulses[1] == 6) ? mres[1][15:0] : (pulses[1] >= 7) ? mres[1][31:16] : 16'h0;

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (done_w[0] === 1'b1) begin
            done_seen[0]++;
            checks++;
            if (exp_q0.size() == 0) begin
                errors++;
                $display("FAIL sb0_unexpected_done: got result=%h, required no done", result_w[0]);
            end else begin
                exp0_v = exp_q0.pop_front();
                if (result_w[0] !== exp0_v) begin
                    errors++;
                    $display("FAIL sb0_result: got %h required %h", result_w[0], exp0_v);
                end
            end
            checks++;
            if (busy_w[0] !== 1'b1) begin
                errors++;
                $display("FAIL sb0_busy_at_done: got %b required 1", busy_w[0]);
            end
        end
        if (done_w[1] === 1'b1) begin
            done_seen[1]++;
            checks++;
            if (exp_q1.size() == 0) begin
                errors++;
                $display("FAIL sb1_unexpected_done: got result=%h, required no done", result_w[1]);
            end else begin
                exp1_v = exp_q1.pop_front();
                if (result_w[1] !== exp1_v) begin
                    errors++;
                    $display("FAIL sb1_result: got %h required %h", result_w[1], exp1_v);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic launch(input int k, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] f, input logic [31:0] expv);
        @(negedge clk);
        start_w[k] = 1'b1;
        op_a_w[k]  = a;
        op_b_w[k]  = b;
        func_w[k]  = f;
        if (k == 0) exp_q0.push_back(expv);
        else        exp_q1.push_back(expv);
        $display("start dut%0d: a=%h b=%h func=%0d expect=%h", k, a, b, f, expv);
        @(negedge clk);
        start_w[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int budget, output int cyc);
        cyc = 1;
        while (done_w[k] !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        $display("done dut%0d: cycle=%0d result=%h", k, cyc, result_w[k]);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        #12;
        checks++; if (busy_w[0] !== 1'b0)   begin errors++; $display("FAIL rst_busy: got %b required 0", busy_w[0]); end
        checks++; if (done_w[0] !== 1'b0)   begin errors++; $display("FAIL rst_done: got %b required 0", done_w[0]); end
        checks++; if (result_w[0] !== 32'h0) begin errors++; $display("FAIL rst_result: got %h required 0", result_w[0]); end
        checks++; if (alu_in_w[0] !== 16'h0) begin errors++; $display("FAIL rst_alu_in: got %h required 0", alu_in_w[0]); end
        checks++; if (alu_func_w[0] !== 4'h0) begin errors++; $display("FAIL rst_alu_func: got %h required 0", alu_func_w[0]); end
        checks++; if (alu_next_w[0] !== 1'b0) begin errors++; $display("FAIL rst_alu_next: got %b required 0", alu_next_w[0]); end
        checks++; if (alu_clr_w[0] !== 1'b1) begin errors++; $display("FAIL rst_alu_clr: got %b required 1", alu_clr_w[0]); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (alu_clr_w[0] !== 1'b0) begin errors++; $display("FAIL idle_alu_clr: got %b required 0", alu_clr_w[0]); end
    endtask

    task automatic test_add();
        int cyc;
        launch(0, 32'h0007_0002, 32'h0003_0003, 4'd0, 32'h000A_0005);
        wait_done(0, 60, cyc);
        checks++; if (cyc != 23) begin errors++; $display("FAIL add_latency: got %0d required 23", cyc); end
        checks++; if (rec[0][0] !== 16'h0002) begin errors++; $display("FAIL add_beat_alo: got %h required 0002", rec[0][0]); end
        checks++; if (rec[0][1] !== 16'h0007) begin errors++; $display("FAIL add_beat_ahi: got %h required 0007", rec[0][1]); end
        checks++; if (rec[0][2] !== 16'h0003) begin errors++; $display("FAIL add_beat_blo: got %h required 0003", rec[0][2]); end
        checks++; if (rec[0][3] !== 16'h0003) begin errors++; $display("FAIL add_beat_bhi: got %h required 0003", rec[0][3]); end
        checks++; if (ex_in[0] !== 16'h0) begin errors++; $display("FAIL add_ex_in: got %h required 0", ex_in[0]); end
        checks++; if (pulses[0] != 7) begin errors++; $display("FAIL add_pulse_count: got %0d required 7", pulses[0]); end
        checks++; if (wmin[0] != 1 || wmax[0] != 1) begin errors++; $display("FAIL add_pulse_width: got min %0d max %0d required 1", wmin[0], wmax[0]); end
        repeat (3) @(negedge clk);
        checks++; if (result_w[0] !== 32'h000A_0005) begin errors++; $display("FAIL add_result_hold: got %h required 000a0005", result_w[0]); end
        checks++; if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL add_idle_busy: got %b required 0", busy_w[0]); end
    endtask

    task automatic test_sub();
        int cyc;
        launch(0, 32'h0003_0003, 32'h000B_0001, 4'd1, 32'hFFF8_0002);
        wait_done(0, 60, cyc);
        checks++; if (cyc != 23) begin errors++; $display("FAIL sub_latency: got %0d required 23", cyc); end
        checks++; if (mfunc[0] !== 4'd1) begin errors++; $display("FAIL sub_func: got %0d required 1", mfunc[0]); end
    endtask

    task automatic test_sra();
        int cyc;
        launch(0, 32'hB885_264A, 32'h0000_0001, 4'd7, 32'hDC42_9325);
        wait_done(0, 60, cyc);
        checks++; if (cyc != 23) begin errors++; $display("FAIL sra_latency: got %0d required 23", cyc); end
        repeat (4) @(negedge clk);
        checks++; if (alu_func_w[0] !== 4'd7) begin errors++; $display("FAIL sra_func_hold: got %0d required 7", alu_func_w[0]); end
    endtask

    task automatic test_start_ignored();
        int cyc;
        int d0;
        bit busy_ok;
        d0 = done_seen[0];
        busy_ok = 1'b1;
        launch(0, 32'h0805_020A, 32'h000F_0212, 4'd4, 32'h080A_0018);
        cyc = 1;
        while (done_w[0] !== 1'b1 && cyc < 60) begin
            if (busy_w[0] !== 1'b1) busy_ok = 1'b0;
            if (cyc == 5 || cyc == 12) begin
                start_w[0] = 1'b1;
                op_a_w[0]  = 32'hFFFF_0000 + 32'(cyc);
                op_b_w[0]  = 32'h1234_5678;
                func_w[0]  = 4'd0;
            end else begin
                start_w[0] = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        $display("done dut0: cycle=%0d result=%h", cyc, result_w[0]);
        checks++; if (cyc != 23) begin errors++; $display("FAIL xor_latency: got %0d required 23", cyc); end
        checks++; if (!busy_ok) begin errors++; $display("FAIL xor_busy_continuous: got gap required none"); end
        checks++; if (rec[0][0] !== 16'h020A || rec[0][1] !== 16'h0805) begin
            errors++; $display("FAIL xor_latched_a: got %h%h required 0805020a", rec[0][1], rec[0][0]);
        end
        // start during the DONE cycle must be dropped
        start_w[0] = 1'b1;
        op_a_w[0]  = 32'h1;
        @(negedge clk);
        start_w[0] = 1'b0;
        checks++; if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL done_cycle_start: got busy %b required 0", busy_w[0]); end
        repeat (30) @(negedge clk);
        checks++; if (done_seen[0] - d0 != 1) begin errors++; $display("FAIL xor_done_count: got %0d required 1", done_seen[0] - d0); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int d0;
        launch(0, 32'h00F0_0F00, 32'h0F0F_00FF, 4'd3, 32'h0FFF_0FFF);
        repeat (8) @(negedge clk);
        d0 = done_seen[0];
        #1 reset = 1'b0;
        exp_q0.delete();
        #1;
        $display("reset asserted mid-op: busy=%b result=%h alu_in=%h", busy_w[0], result_w[0], alu_in_w[0]);
        checks++; if (busy_w[0] !== 1'b0)    begin errors++; $display("FAIL mid_rst_busy: got %b required 0", busy_w[0]); end
        checks++; if (done_w[0] !== 1'b0)    begin errors++; $display("FAIL mid_rst_done: got %b required 0", done_w[0]); end
        checks++; if (result_w[0] !== 32'h0) begin errors++; $display("FAIL mid_rst_result: got %h required 0", result_w[0]); end
        checks++; if (alu_in_w[0] !== 16'h0) begin errors++; $display("FAIL mid_rst_alu_in: got %h required 0", alu_in_w[0]); end
        checks++; if (alu_func_w[0] !== 4'h0) begin errors++; $display("FAIL mid_rst_alu_func: got %h required 0", alu_func_w[0]); end
        checks++; if (alu_next_w[0] !== 1'b0) begin errors++; $display("FAIL mid_rst_alu_next: got %b required 0", alu_next_w[0]); end
        checks++; if (alu_clr_w[0] !== 1'b1) begin errors++; $display("FAIL mid_rst_alu_clr: got %b required 1", alu_clr_w[0]); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        checks++; if (done_seen[0] != d0) begin errors++; $display("FAIL mid_rst_no_done: got %0d dones required 0", done_seen[0] - d0); end
        launch(0, 32'h0007_0002, 32'h0003_0003, 4'd0, 32'h000A_0005);
        wait_done(0, 60, cyc);
        checks++; if (cyc != 23) begin errors++; $display("FAIL post_rst_add_latency: got %0d required 23", cyc); end
        @(negedge clk);
    endtask

    task automatic test_slow();
        int cyc;
        launch(1, 32'h0825_220A, 32'h0000_0000, 4'd5, 32'hF7DA_DDF5);
        wait_done(1, 80, cyc);
        checks++; if (cyc != 37) begin errors++; $display("FAIL slow_latency: got %0d required 37", cyc); end
        checks++; if (wmin[1] != 2 || wmax[1] != 2) begin errors++; $display("FAIL slow_pulse_width: got min %0d max %0d required 2", wmin[1], wmax[1]); end
        checks++; if (pulses[1] != 7) begin errors++; $display("FAIL slow_pulse_count: got %0d required 7", pulses[1]); end
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            start_w[k] = 1'b0;
            op_a_w[k]  = 32'h0;
            op_b_w[k]  = 32'h0;
            func_w[k]  = 4'h0;
        end
        test_reset();
        test_add();
        test_sub();
        test_sra();
        test_start_ignored();
        test_reset_mid();
        test_slow();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d/%0d pending required 0", exp_q0.size(), exp_q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

endmodule
